// File: rtl/store_drain_ctrl.sv
// store_drain_ctrl
// Drains committed stores from the store queue into the single D-cache port,
// one at a time and oldest first. The port is shared with the load pipeline.
// Loads normally win. Stores take the port when the backlog reaches
// HIGH_WATER, or when a pending store has lost STARVE_LIMIT arbitrations in
// a row.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   commit_store_cnt    stores committed this cycle
//   sq_addr/data/be     store-queue entry at drain_ptr
//   ld_req_valid/addr   load pipeline request for the cache port
//   ld_grant            load owns the port this cycle
//   mem_req_*           cache request (load pass-through or latched store)
//   mem_req_ready       cache accepts the request
//   mem_wr_done         store write complete
//   drain_ptr           store-queue entry being drained
//   sq_release          one-cycle pulse that frees the store-queue head
//   pending_cnt         committed but not yet drained stores
//   commit_stall        backlog too high to accept a full commit group
module store_drain_ctrl #(
  parameter int SQ_SIZE      = 8,
  parameter int COMMIT_WIDTH = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int HIGH_WATER   = 6,
  parameter int STARVE_LIMIT = 4,
  localparam int SQ_IDX      = $clog2(SQ_SIZE),
  localparam int CNT_W       = $clog2(COMMIT_WIDTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  commit_store_cnt,
  input  logic [ADDR_W-1:0] sq_addr,
  input  logic [DATA_W-1:0] sq_data,
  input  logic [3:0]        sq_be,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_grant,
  output logic              mem_req_valid,
  output logic              mem_req_is_store,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic [3:0]        mem_req_be,
  input  logic              mem_req_ready,
  input  logic              mem_wr_done,
  output logic [SQ_IDX-1:0] drain_ptr,
  output logic              sq_release,
  output logic [SQ_IDX:0]   pending_cnt,
  output logic              commit_stall
);

  localparam int PEND_W = SQ_IDX + 1;
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [PEND_W-1:0] HW_TH    = PEND_W'(HIGH_WATER);
  localparam logic [PEND_W-1:0] STALL_TH = PEND_W'(SQ_SIZE - COMMIT_WIDTH);
  localparam logic [PEND_W:0]   PEND_MAX = (PEND_W + 1)'(SQ_SIZE);
  localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ST_REQ, ST_WAIT} state_t;

  state_t            state, state_nxt;
  logic [STV_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [3:0]        lat_be;

  logic              has_pending;
  logic              store_prio;
  logic              ld_win;
  logic              store_start;
  logic [PEND_W:0]   pend_sum;

  assign has_pending  = (pending_cnt != '0);
  assign store_prio   = (pending_cnt >= HW_TH) || (starve_cnt == STV_MAX);
  // A load only loses in IDLE when a store is actually waiting and has priority.
  assign ld_win       = (state == IDLE) && ld_req_valid && !(has_pending && store_prio);
  assign store_start  = (state == IDLE) && !ld_win && has_pending;
  assign commit_stall = (pending_cnt > STALL_TH);
  // One extra bit so an overflow past SQ_SIZE is visible to the assertion.
  assign pend_sum     = {1'b0, pending_cnt} + (PEND_W + 1)'(commit_store_cnt)
                        - (PEND_W + 1)'(sq_release);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (store_start)   state_nxt = ST_REQ;
      ST_REQ:  if (mem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_wr_done)   state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ld_grant         = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_is_store = 1'b0;
    mem_req_addr     = '0;
    mem_req_data     = '0;
    mem_req_be       = '0;
    sq_release       = 1'b0;
    case (state)
      IDLE: begin
        if (ld_win) begin
          ld_grant      = 1'b1;
          mem_req_valid = 1'b1;
          mem_req_addr  = ld_req_addr;
        end
      end
      ST_REQ: begin
        mem_req_valid    = 1'b1;
        mem_req_is_store = 1'b1;
        mem_req_addr     = lat_addr;
        mem_req_data     = lat_data;
        mem_req_be       = lat_be;
      end
      ST_WAIT: sq_release = mem_wr_done;
      default: ;
    endcase
  end

  // Counters, drain pointer and store latches
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cnt <= '0;
      drain_ptr   <= '0;
      starve_cnt  <= '0;
      lat_addr    <= '0;
      lat_data    <= '0;
      lat_be      <= '0;
    end else begin
      assert (pend_sum <= PEND_MAX)
        else $error("store_drain_ctrl: pending_cnt overflow (commit ignored commit_stall)");
      pending_cnt <= pend_sum[PEND_W-1:0];
      // Power-of-two queue: the pointer wraps naturally.
      if (sq_release) drain_ptr <= drain_ptr + SQ_IDX'(1);
      if (store_start) begin
        starve_cnt <= '0;
        lat_addr   <= sq_addr;
        lat_data   <= sq_data;
        lat_be     <= sq_be;
      end else if (ld_win && has_pending && (starve_cnt != STV_MAX)) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Scoreboard bench for store_drain_ctrl. Stimulus pushes expected stores,
// loads and release pointers into queues; the monitor pops and compares them
// whenever the DUT accepts a store, grants a load or pulses sq_release.
module tb_store_drain_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  commit_store_cnt;
  logic [31:0] sq_addr, sq_data;
  logic [3:0]  sq_be;
  logic        ld_req_valid;
  logic [31:0] ld_req_addr;
  logic        ld_grant;
  logic        mem_req_valid, mem_req_is_store;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_req_ready, mem_wr_done;
  logic [2:0]  drain_ptr;
  logic        sq_release;
  logic [3:0]  pending_cnt;
  logic        commit_stall;

  int checks = 0;
  int errors = 0;
  int rel_seen = 0;
  int serial = 0;
  int tail = 0;
  st_t last;

  st_t         st_q[$];
  logic [31:0] ld_q[$];
  int          rel_q[$];

  logic [31:0] sq_a[8];
  logic [31:0] sq_d[8];
  logic [3:0]  sq_b[8];

  assign sq_addr = sq_a[drain_ptr];
  assign sq_data = sq_d[drain_ptr];
  assign sq_be   = sq_b[drain_ptr];

  always #5 clk = ~clk;

  store_drain_ctrl #(
    .SQ_SIZE(8), .COMMIT_WIDTH(4), .ADDR_W(32), .DATA_W(32),
    .HIGH_WATER(6), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .commit_store_cnt(commit_store_cnt),
    .sq_addr(sq_addr), .sq_data(sq_data), .sq_be(sq_be),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_grant(ld_grant),
    .mem_req_valid(mem_req_valid), .mem_req_is_store(mem_req_is_store),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_be(mem_req_be),
    .mem_req_ready(mem_req_ready), .mem_wr_done(mem_wr_done),
    .drain_ptr(drain_ptr), .sq_release(sq_release),
    .pending_cnt(pending_cnt), .commit_stall(commit_stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Writes n new entries at the queue tail and records what must come out.
  task automatic commit(input int n);
    commit_store_cnt = 3'(n);
    for (int i = 0; i < n; i++) begin
      st_t e;
      e.addr = 32'hA000_0000 + 32'(serial) * 32'h40;
      e.data = 32'hD000_0000 + 32'(serial);
      e.be   = 4'(serial % 15 + 1);
      sq_a[tail] = e.addr;
      sq_d[tail] = e.data;
      sq_b[tail] = e.be;
      st_q.push_back(e);
      rel_q.push_back(tail);
      last = e;
      tail = (tail + 1) % 8;
      serial++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (pending_cnt != 0 && n < budget) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < budget), 1);
  endtask

  task automatic wait_no_stall(input int budget);
    int n = 0;
    @(negedge clk);
    while (commit_stall && n < budget) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    chk("stall_timeout", 64'(n < budget), 1);
  endtask

  // Monitor
  always @(negedge clk) begin
    st_t e;
    if (!rst) begin
      if (mem_req_valid && mem_req_is_store && mem_req_ready) begin
        if (st_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_store: got addr 0x%0h, expected no store", mem_req_addr);
        end else begin
          e = st_q.pop_front();
          chk("st_addr", mem_req_addr, e.addr);
          chk("st_data", mem_req_data, e.data);
          chk("st_be", mem_req_be, e.be);
          chk("st_ld_grant", ld_grant, 0);
        end
      end
      if (ld_grant) begin
        if (ld_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got grant addr 0x%0h, expected no grant", mem_req_addr);
        end else begin
          chk("ld_addr", mem_req_addr, ld_q.pop_front());
          chk("ld_valid", mem_req_valid, 1);
          chk("ld_is_store", mem_req_is_store, 0);
          chk("ld_data", mem_req_data, 0);
          chk("ld_be", mem_req_be, 0);
        end
      end
      if (sq_release) begin
        rel_seen++;
        if (rel_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_release: got release at ptr %0d, expected none", drain_ptr);
        end else begin
          chk("rel_ptr", drain_ptr, rel_q.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    commit_store_cnt = '0;
    ld_req_valid = 1'b0;
    ld_req_addr = '0;
    mem_req_ready = 1'b1;
    mem_wr_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sq_a[i] = '0; sq_d[i] = '0; sq_b[i] = '0;
    end
    next(); next();
    @(negedge clk);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_drain", drain_ptr, 0);
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_release", sq_release, 0);
    chk("rst_grant", ld_grant, 0);
    chk("rst_stall", commit_stall, 0);

    // Single store, no loads: decide, request, release
    next(); rst = 1'b0; commit(1);
    @(negedge clk); chk("t1_pend0", pending_cnt, 0);
    next(); commit_store_cnt = '0;
    @(negedge clk); chk("t1_pend1", pending_cnt, 1); chk("t1_idle_valid", mem_req_valid, 0);
    next();
    @(negedge clk); chk("t1_req_valid", mem_req_valid, 1); chk("t1_req_store", mem_req_is_store, 1);
    next();
    @(negedge clk); chk("t1_release", sq_release, 1); chk("t1_wait_valid", mem_req_valid, 0);
    next();
    @(negedge clk); chk("t1_drain", drain_ptr, 1); chk("t1_pend_end", pending_cnt, 0);
    chk("t1_rel_end", sq_release, 0);

    // Starvation override: one free load, four lost arbitrations, then store forced
    next(); commit(3); ld_req_valid = 1'b1; ld_req_addr = 32'h0000_4000;
    ld_q.push_back(32'h0000_4000);
    @(negedge clk); chk("t2_pend0", pending_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      next(); commit_store_cnt = '0; ld_q.push_back(32'h0000_4000);
      @(negedge clk); chk("t2_pend", pending_cnt, 3);
    end
    next();
    @(negedge clk); chk("t2_forced_grant", ld_grant, 0); chk("t2_forced_valid", mem_req_valid, 0);
    next();
    @(negedge clk); chk("t2_req_grant", ld_grant, 0); chk("t2_req_store", mem_req_is_store, 1);
    next();
    @(negedge clk); chk("t2_wait_grant", ld_grant, 0); chk("t2_wait_rel", sq_release, 1);
    next(); ld_req_valid = 1'b0;
    wait_idle(60);
    chk("t2_drain", drain_ptr, 4);

    // High-water override and commit_stall
    next(); commit(4); ld_req_valid = 1'b1; ld_req_addr = 32'h0000_5000;
    ld_q.push_back(32'h0000_5000);
    @(negedge clk); chk("t3_stall0", commit_stall, 0);
    next(); commit(2); ld_q.push_back(32'h0000_5000);
    @(negedge clk); chk("t3_pend4", pending_cnt, 4); chk("t3_stall4", commit_stall, 0);
    next(); commit_store_cnt = '0;
    @(negedge clk); chk("t3_pend6", pending_cnt, 6); chk("t3_stall6", commit_stall, 1);
    chk("t3_hw_grant", ld_grant, 0); chk("t3_hw_valid", mem_req_valid, 0);
    next(); ld_req_valid = 1'b0;
    @(negedge clk); chk("t3_req_store", mem_req_is_store, 1);
    wait_idle(60);
    chk("t3_drain", drain_ptr, 2); chk("t3_stall_end", commit_stall, 0);

    // Back-pressure in ST_REQ, then commit coinciding with release
    next(); commit(1); mem_req_ready = 1'b0;
    next(); commit_store_cnt = '0;
    @(negedge clk); chk("t5_pend1", pending_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      next();
      @(negedge clk);
      chk("t5_hold_valid", mem_req_valid, 1);
      chk("t5_hold_store", mem_req_is_store, 1);
      chk("t5_hold_addr", mem_req_addr, last.addr);
      chk("t5_hold_data", mem_req_data, last.data);
      chk("t5_hold_be", mem_req_be, last.be);
    end
    next(); mem_req_ready = 1'b1;
    @(negedge clk); chk("t5_accept_valid", mem_req_valid, 1);
    next(); commit(2);
    @(negedge clk); chk("t5_rel", sq_release, 1); chk("t5_pend_rel", pending_cnt, 1);
    next(); commit_store_cnt = '0;
    @(negedge clk); chk("t5_pend_net", pending_cnt, 2);
    wait_idle(60);
    chk("t5_drain", drain_ptr, 5);

    // Reset while a store sits in ST_WAIT
    next(); commit(3); mem_wr_done = 1'b0;
    next(); commit_store_cnt = '0;
    next();
    @(negedge clk); chk("t6_req_store", mem_req_is_store, 1);
    next();
    @(negedge clk); chk("t6_wait_valid", mem_req_valid, 0); chk("t6_wait_rel", sq_release, 0);
    next(); rst = 1'b1;
    @(negedge clk); chk("t6_pend3", pending_cnt, 3);
    next(); rst = 1'b0; mem_wr_done = 1'b1;
    st_q.delete(); rel_q.delete(); tail = 0;
    @(negedge clk);
    chk("t6_pend", pending_cnt, 0); chk("t6_drain", drain_ptr, 0);
    chk("t6_rel", sq_release, 0); chk("t6_valid", mem_req_valid, 0);
    chk("t6_stall", commit_stall, 0);
    next();
    @(negedge clk); chk("t6_pend_after", pending_cnt, 0); chk("t6_rel_after", sq_release, 0);

    // Nine stores through a full pointer wrap
    base = rel_seen;
    next(); commit(4);
    next(); commit(4);
    @(negedge clk); chk("t4_pend4", pending_cnt, 4);
    next(); commit_store_cnt = '0;
    @(negedge clk); chk("t4_pend8", pending_cnt, 8); chk("t4_stall8", commit_stall, 1);
    wait_no_stall(60);
    next(); commit(1);
    next(); commit_store_cnt = '0;
    wait_idle(100);
    chk("t4_drain", drain_ptr, 1);
    chk("t4_releases", 64'(rel_seen - base), 9);

    next(); next();
    chk("st_q_empty", 64'(st_q.size()), 0);
    chk("ld_q_empty", 64'(ld_q.size()), 0);
    chk("rel_q_empty", 64'(rel_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_drain_ctrl.md
Name: store_drain_ctrl

Overview:
Sequences committed stores out of the store queue into the single data-cache port, one store at a time, oldest first. Shares that port with the load pipeline through a priority arbiter with a high-water override and a starvation override. Sits between commit (which reports stores committed per cycle) and the store queue/D-cache. Owns the store-queue drain pointer and the head-release pulse.

Parameters:
SQ_SIZE, 8, store-queue entries (power of two); SQ_IDX = log2(SQ_SIZE)
COMMIT_WIDTH, 4, max stores committed per cycle
ADDR_W, 32, address width
DATA_W, 32, data width
HIGH_WATER, 6, pending_cnt at or above this gives stores priority over loads
STARVE_LIMIT, 4, consecutive lost arbitrations before a pending store is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
commit_store_cnt  in  log2(COMMIT_WIDTH)+1  stores committed this cycle
sq_addr  in  ADDR_W  store-queue address at drain_ptr
sq_data  in  DATA_W  store-queue data at drain_ptr
sq_be  in  4  byte enables at drain_ptr
ld_req_valid  in  1  load pipeline requests the cache port
ld_req_addr  in  ADDR_W  load address
ld_grant  out  1  load owns the port this cycle
mem_req_valid  out  1  cache request valid
mem_req_is_store  out  1  1 = store, 0 = load
mem_req_addr  out  ADDR_W  request address
mem_req_data  out  DATA_W  store data; 0 for loads
mem_req_be  out  4  store byte enables; 0 for loads
mem_req_ready  in  1  cache accepts the request this cycle
mem_wr_done  in  1  store write complete
drain_ptr  out  SQ_IDX  store-queue entry being drained
sq_release  out  1  one-cycle pulse: free the store-queue head
pending_cnt  out  SQ_IDX+1  committed but not yet drained stores
commit_stall  out  1  pending_cnt > SQ_SIZE - COMMIT_WIDTH

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; pending_cnt=0, drain_ptr=0, starve_cnt=0.
  - Address/data/byte-enable latches cleared.
  - All outputs 0 the following cycle. An in-flight store is abandoned; the store queue resets too.
- pending_cnt next = pending_cnt + commit_store_cnt - sq_release. Both terms apply in the same cycle.
  - Overflow past SQ_SIZE is a protocol error; commit must honour commit_stall. The simulation assertion fires on overflow.
- store_prio = (pending_cnt >= HIGH_WATER) or (starve_cnt == STARVE_LIMIT).
- FSM states IDLE, ST_REQ, ST_WAIT.
- IDLE:
  - If ld_req_valid and not (pending_cnt>0 and store_prio): ld_grant=1 and the load passes through combinationally (mem_req_valid=1, is_store=0, mem_req_addr=ld_req_addr).
  - Otherwise, if pending_cnt>0: latch sq_addr/sq_data/sq_be and go to ST_REQ next cycle.
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle a load wins while pending_cnt>0. It clears when a store enters ST_REQ.
- ST_REQ:
  - mem_req_valid=1, is_store=1, latched addr/data/be driven; ld_grant=0.
  - Go to ST_WAIT on mem_req_ready; otherwise hold with all fields stable.
- ST_WAIT:
  - mem_req_valid=0, ld_grant=0.
  - On mem_wr_done: sq_release=1 (combinational, that cycle), drain_ptr += 1 modulo SQ_SIZE, pending_cnt -= 1, go to IDLE.
  - Minimum store occupancy is 3 cycles (IDLE decision, REQ with ready, WAIT with done).
- mem_wr_done outside ST_WAIT is ignored; mem_req_ready outside ST_REQ is ignored for stores.
- drain_ptr wraps from SQ_SIZE-1 to 0 with no special handling.
- commit_stall is purely combinational from pending_cnt.

Test Plan:
- Reset then commit_store_cnt=1 once, no loads, ready and done tied high -> ST_REQ at cycle 2 with sq_addr latched; sq_release pulses at cycle 3; drain_ptr=1; pending_cnt back to 0.
- commit_store_cnt=3 with ld_req_valid held 1 -> loads granted for 4 cycles (starve_cnt 0..4), then the store is forced; ld_grant=0 during ST_REQ/ST_WAIT.
- commit_store_cnt=4 then 2 (pending=6) with ld_req_valid=1 -> the store wins immediately (high-water); commit_stall=1 while pending_cnt>4.
- Drain 9 stores with ready and done high -> drain_ptr sequence 1..7,0,1; exactly 9 sq_release pulses.
- mem_req_ready low for 5 cycles in ST_REQ -> addr/data/be stable, mem_req_valid held 1; commit_store_cnt=2 arriving on the same cycle as sq_release -> pending_cnt net +1.
- rst asserted during ST_WAIT with pending_cnt=3 -> next cycle IDLE, pending_cnt=0, drain_ptr=0, sq_release=0, mem_req_valid=0.
